regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_if.sv | 31 +++
 rtl/regfile_sb.sv | 108 ++++++++++
 tb/tb_regfile_sb.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Bundle of the register-file ports: read ports, write ports, issue/flush control
// and the status outputs. The master drives requests and the slave (the register
// file) returns data and status.
interface regfile_sb_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5,
  parameter int unsigned NR = 2,
  parameter int unsigned NW = 2
);
  logic [NR*AW-1:0] rd_idx;
  logic [NR*DW-1:0] rd_dat;
  logic [NR-1:0]    rd_busy;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_idx;
  logic [NW*DW-1:0] wr_dat;
  logic             iss_en;
  logic [AW-1:0]    iss_idx;
  logic             flush;
  logic [AW:0]      busy_cnt;
  logic [DW-1:0]    x1_r;

  modport master (
    output rd_idx, wr_en, wr_idx, wr_dat, iss_en, iss_idx, flush,
    input  rd_dat, rd_busy, busy_cnt, x1_r
  );

  modport slave (
    input  rd_idx, wr_en, wr_idx, wr_dat, iss_en, iss_idx, flush,
    output rd_dat, rd_busy, busy_cnt, x1_r
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-port register file with a per-register scoreboard (busy bits).
// Register 0 is hard-wired to zero. Reads bypass same-cycle writes; busy bits are
// set on issue, cleared on writeback, and all cleared by flush.
// The parameters must match those of the connected regfile_sb_if instance.
module regfile_sb #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5,
  parameter int unsigned NR = 2,
  parameter int unsigned NW = 2
) (
  input logic        clk,
  input logic        rst,
  regfile_sb_if.slave bus
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0]    mem_q [Depth];
  logic [Depth-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;

  // Register storage: ascending port order so the highest-numbered port wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int k = 0; k < NW; k++) begin
        if (bus.wr_en[k] && (bus.wr_idx[k*AW +: AW] != '0)) begin
          mem_q[bus.wr_idx[k*AW +: AW]] <= bus.wr_dat[k*DW +: DW];
        end
      end
    end
  end

  // Next busy vector: writeback clears, issue sets (issue beats writeback), flush clears all.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NW; k++) begin
      if (bus.wr_en[k]) begin
        busy_d[bus.wr_idx[k*AW +: AW]] = 1'b0;
      end
    end
    if (bus.iss_en) begin
      busy_d[bus.iss_idx] = 1'b1;
    end
    if (bus.flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // Population count of the next busy vector; bit 0 is always clear so it never wraps.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < Depth; i++) begin
      cnt_d = cnt_d + (AW+1)'(busy_d[i]);
    end
  end

  // Scoreboard state and registered busy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Read ports: write bypass (highest matching port wins), busy masked by bypass hit.
  always_comb begin
    logic [AW-1:0] ridx;
    logic [DW-1:0] rdat;
    logic          hit;
    bus.rd_dat  = '0;
    bus.rd_busy = '0;
    ridx        = '0;
    rdat        = '0;
    hit         = 1'b0;
    for (int p = 0; p < NR; p++) begin
      ridx = bus.rd_idx[p*AW +: AW];
      rdat = mem_q[ridx];
      hit  = 1'b0;
      for (int k = 0; k < NW; k++) begin
        if (bus.wr_en[k] && (bus.wr_idx[k*AW +: AW] == ridx)) begin
          rdat = bus.wr_dat[k*DW +: DW];
          hit  = 1'b1;
        end
      end
      if (ridx == '0) begin
        rdat = '0;
        hit  = 1'b1;
      end
      bus.rd_dat[p*DW +: DW] = rdat;
      bus.rd_busy[p]         = busy_q[ridx] & ~hit;
    end
  end

  // Status outputs straight from state.
  always_comb begin
    bus.busy_cnt = cnt_q;
    bus.x1_r     = mem_q[1];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset state, write bypass and priority, scoreboard
// issue/writeback/flush behaviour, reset override and register-0 handling.
module tb_regfile_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned NW = 2;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  regfile_sb_if #(.DW(DW), .AW(AW), .NR(NR), .NW(NW)) bus ();

  regfile_sb #(.DW(DW), .AW(AW), .NR(NR), .NW(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en   = '0;
    bus.wr_idx  = '0;
    bus.wr_dat  = '0;
    bus.iss_en  = 1'b0;
    bus.iss_idx = '0;
    bus.flush   = 1'b0;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    bus.rd_idx = '0;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Reset state: every register reads zero and not busy.
    for (int i = 0; i < 32; i++) begin
      bus.rd_idx = {5'(31 - i), 5'(i)};
      #1;
      check($sformatf("rst_dat0_%0d", i), 64'(bus.rd_dat[31:0]), 64'h0);
      check($sformatf("rst_dat1_%0d", i), 64'(bus.rd_dat[63:32]), 64'h0);
      check($sformatf("rst_busy_%0d", i), 64'(bus.rd_busy), 64'h0);
    end
    check("rst_cnt", 64'(bus.busy_cnt), 64'd0);
    check("rst_x1", 64'(bus.x1_r), 64'h0);

    // Both write ports hit index 5: port 1 wins for bypass and storage.
    bus.wr_en  = 2'b11;
    bus.wr_idx = {5'd5, 5'd5};
    bus.wr_dat = {32'hBBBB, 32'hAAAA};
    bus.rd_idx = {5'd0, 5'd5};
    #1;
    check("prio_bypass", 64'(bus.rd_dat[31:0]), 64'hBBBB);
    tick();
    idle();
    #1;
    check("prio_stored", 64'(bus.rd_dat[31:0]), 64'hBBBB);

    // Issue 7, then writeback 7.
    bus.iss_en  = 1'b1;
    bus.iss_idx = 5'd7;
    tick();
    idle();
    bus.rd_idx = {5'd5, 5'd7};
    #1;
    check("iss7_busy", 64'(bus.rd_busy[0]), 64'd1);
    check("iss7_other_busy", 64'(bus.rd_busy[1]), 64'd0);
    check("iss7_cnt", 64'(bus.busy_cnt), 64'd1);
    bus.wr_en  = 2'b01;
    bus.wr_idx = {5'd0, 5'd7};
    bus.wr_dat = {32'h0, 32'h1234};
    #1;
    check("wb7_busy_masked", 64'(bus.rd_busy[0]), 64'd0);
    check("wb7_bypass", 64'(bus.rd_dat[31:0]), 64'h1234);
    tick();
    idle();
    #1;
    check("wb7_cnt", 64'(bus.busy_cnt), 64'd0);
    check("wb7_busy", 64'(bus.rd_busy[0]), 64'd0);
    check("wb7_stored", 64'(bus.rd_dat[31:0]), 64'h1234);

    // Issue and write to 3 in the same cycle: stays busy, data committed.
    bus.iss_en  = 1'b1;
    bus.iss_idx = 5'd3;
    bus.wr_en   = 2'b10;
    bus.wr_idx  = {5'd3, 5'd0};
    bus.wr_dat  = {32'h3333, 32'h0};
    tick();
    idle();
    bus.rd_idx = {5'd0, 5'd3};
    #1;
    check("iss_wr3_busy", 64'(bus.rd_busy[0]), 64'd1);
    check("iss_wr3_dat", 64'(bus.rd_dat[31:0]), 64'h3333);
    check("iss_wr3_cnt", 64'(bus.busy_cnt), 64'd1);

    // Issue 1..31: count saturates at 31 (3 was already busy).
    for (int i = 1; i < 32; i++) begin
      bus.iss_en  = 1'b1;
      bus.iss_idx = 5'(i);
      tick();
    end
    idle();
    #1;
    check("iss_all_cnt", 64'(bus.busy_cnt), 64'd31);

    // Flush with a concurrent issue of 9 and a write to 10.
    bus.flush   = 1'b1;
    bus.iss_en  = 1'b1;
    bus.iss_idx = 5'd9;
    bus.wr_en   = 2'b01;
    bus.wr_idx  = {5'd0, 5'd10};
    bus.wr_dat  = {32'h0, 32'h0A10};
    tick();
    idle();
    #1;
    check("flush_cnt", 64'(bus.busy_cnt), 64'd0);
    for (int i = 0; i < 32; i++) begin
      bus.rd_idx = {5'(31 - i), 5'(i)};
      #1;
      check($sformatf("flush_busy_%0d", i), 64'(bus.rd_busy), 64'h0);
    end
    bus.rd_idx = {5'd0, 5'd10};
    #1;
    check("flush_wr_commit", 64'(bus.rd_dat[31:0]), 64'h0A10);

    // Make 4 busy, then reset with a write to 1 and an issue to 6.
    bus.iss_en  = 1'b1;
    bus.iss_idx = 5'd4;
    tick();
    idle();
    #1;
    check("pre_rst_cnt", 64'(bus.busy_cnt), 64'd1);
    rst         = 1'b1;
    bus.iss_en  = 1'b1;
    bus.iss_idx = 5'd6;
    bus.wr_en   = 2'b01;
    bus.wr_idx  = {5'd0, 5'd1};
    bus.wr_dat  = {32'h0, 32'hFFFF};
    bus.rd_idx  = {5'd0, 5'd1};
    #1;
    check("rst_bypass", 64'(bus.rd_dat[31:0]), 64'hFFFF);
    tick();
    rst = 1'b0;
    idle();
    #1;
    check("rst_x1_discard", 64'(bus.x1_r), 64'h0);
    check("rst_rd1", 64'(bus.rd_dat[31:0]), 64'h0);
    check("rst_busy_cnt", 64'(bus.busy_cnt), 64'd0);
    bus.rd_idx = {5'd0, 5'd10};
    #1;
    check("rst_clears_10", 64'(bus.rd_dat[31:0]), 64'h0);

    // Writes and issues to index 0 are ignored.
    bus.wr_en   = 2'b10;
    bus.wr_idx  = {5'd0, 5'd0};
    bus.wr_dat  = {32'h55, 32'h0};
    bus.iss_en  = 1'b1;
    bus.iss_idx = 5'd0;
    bus.rd_idx  = {5'd0, 5'd0};
    #1;
    check("r0_bypass", 64'(bus.rd_dat[31:0]), 64'h0);
    check("r0_busy", 64'(bus.rd_busy[0]), 64'd0);
    tick();
    idle();
    #1;
    check("r0_stored", 64'(bus.rd_dat[31:0]), 64'h0);
    check("r0_cnt", 64'(bus.busy_cnt), 64'd0);

    // x1_r shows storage only, one edge after the write.
    bus.wr_en  = 2'b01;
    bus.wr_idx = {5'd0, 5'd1};
    bus.wr_dat = {32'h0, 32'h77};
    bus.rd_idx = {5'd0, 5'd1};
    #1;
    check("x1_not_bypassed", 64'(bus.x1_r), 64'h0);
    check("x1_rd_bypass", 64'(bus.rd_dat[31:0]), 64'h77);
    tick();
    idle();
    #1;
    check("x1_updated", 64'(bus.x1_r), 64'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
